// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array input skewer.
package systolic_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 32;

  typedef logic [31:0] fp32_t;

  // Sequencer phases: load both matrices, clear accumulators, feed the
  // skewed diagonals, let the array drain, then announce completion.
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } skew_state_e;

endpackage

// File: rtl/skew_lane_mux.sv
// Picks element (t - lane) of a buffered N-vector, or zero when that index
// falls outside 0..N-1. One instance per A row lane and per B column lane.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW     = $clog2(2 * N)
) (
  input  logic [TW-1:0]       lane_i,
  input  logic [TW-1:0]       t_i,
  input  logic [N*DATA_W-1:0] vec_i,
  output logic [DATA_W-1:0]   elem_o
);

  // Element e lines up with this lane exactly when t == lane + e.
  always_comb begin
    elem_o = '0;
    for (int e = 0; e < N; e++) begin
      if (t_i == lane_i + TW'(e)) begin
        elem_o = vec_i[e*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/systolic_input_skewer.sv
// Buffers one A and one B matrix, then replays them diagonally skewed into
// an output-stationary systolic array, waits for the array to drain and
// pulses done.
//
// Load handshake: a beat transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in LOAD, so in_valid in any
// other state is ignored and nothing is stored.
module systolic_input_skewer
  import systolic_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_row,
  input  logic [N*DATA_W-1:0] b_col,
  output logic [N*DATA_W-1:0] sys_a,
  output logic [N*DATA_W-1:0] sys_b,
  output logic                acc_clr,
  output logic                feeding,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state,
  output logic [7:0]          dbg_k
);

  localparam int TW  = $clog2(2 * N);
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  skew_state_e         state_q;
  logic [KW-1:0]       k_q;
  logic [TW-1:0]       t_q;
  logic [TW-1:0]       feed_t_d;
  logic [DCW-1:0]      dcnt_q;
  logic                in_ready_q, acc_clr_q, feeding_q, busy_q, done_q;

  // abuf_q[i] holds row i of A; bbuf_q[j] holds column j of B.
  logic [N*DATA_W-1:0] abuf_q [N];
  logic [N*DATA_W-1:0] bbuf_q [N];

  logic [DATA_W-1:0]   mux_a   [N];
  logic [DATA_W-1:0]   mux_b   [N];
  logic [DATA_W-1:0]   sys_a_q [N];
  logic [DATA_W-1:0]   sys_b_q [N];

  logic                beat_ok;
  assign beat_ok = in_valid && in_ready_q;

  // Outputs are registered, so the lane muxes look at the t that will be on
  // the outputs next cycle: 0 when leaving CLEAR, t+1 while in FEED.
  assign feed_t_d = (state_q == CLEAR) ? '0 : t_q + 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(.N(N), .DATA_W(DATA_W), .TW(TW)) u_a_mux (
      .lane_i (TW'(g)),
      .t_i    (feed_t_d),
      .vec_i  (abuf_q[g]),
      .elem_o (mux_a[g])
    );
    skew_lane_mux #(.N(N), .DATA_W(DATA_W), .TW(TW)) u_b_mux (
      .lane_i (TW'(g)),
      .t_i    (feed_t_d),
      .vec_i  (bbuf_q[g]),
      .elem_o (mux_b[g])
    );
    assign sys_a[g*DATA_W +: DATA_W] = sys_a_q[g];
    assign sys_b[g*DATA_W +: DATA_W] = sys_b_q[g];
  end

  // Capture accepted beats; contents need no reset because every run
  // overwrites all N rows and columns before they are read.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      abuf_q[k_q] <= a_row;
      bbuf_q[k_q] <= b_col;
    end
  end

  // Sequencer with all control outputs and the skewed lanes registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LOAD;
      k_q        <= '0;
      t_q        <= '0;
      dcnt_q     <= '0;
      sys_a_q    <= '{default: '0};
      sys_b_q    <= '{default: '0};
      in_ready_q <= 1'b1;
      acc_clr_q  <= 1'b0;
      feeding_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat_ok) begin
            if (k_q == KW'(N - 1)) begin
              k_q        <= '0;
              state_q    <= CLEAR;
              acc_clr_q  <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        CLEAR: begin
          acc_clr_q <= 1'b0;
          state_q   <= FEED;
          t_q       <= '0;
          feeding_q <= 1'b1;
          sys_a_q   <= mux_a;
          sys_b_q   <= mux_b;
        end
        FEED: begin
          if (t_q == TW'(2 * N - 2)) begin
            state_q   <= DRAIN;
            feeding_q <= 1'b0;
            dcnt_q    <= '0;
            sys_a_q   <= '{default: '0};
            sys_b_q   <= '{default: '0};
          end else begin
            t_q     <= feed_t_d;
            sys_a_q <= mux_a;
            sys_b_q <= mux_b;
          end
        end
        DRAIN: begin
          if (dcnt_q == DCW'(DRAIN_CYCLES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign acc_clr   = acc_clr_q;
  assign feeding   = feeding_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign dbg_k     = 8'(k_q);

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Bench for systolic_input_skewer: a cycle-level model derived from the
// documented timing (cycles since the last accepted beat) and the skew
// formula, checked every cycle, plus hand-computed literal pins.
module tb_systolic_input_skewer;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_row, b_col, sys_a, sys_b;
  logic            acc_clr, feeding, busy, done;
  logic [2:0]      dbg_state;
  logic [7:0]      dbg_k;

  systolic_input_skewer #(.N(N), .DATA_W(DW), .DRAIN_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_row     (a_row),
    .b_col     (b_col),
    .sys_a     (sys_a),
    .sys_b     (sys_b),
    .acc_clr   (acc_clr),
    .feeding   (feeding),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .dbg_k     (dbg_k)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // ---------------- model ----------------
  // Source matrices the driver sends; the model keeps its own copy of what
  // was actually handed over on accepted beats.
  fp32_t src_a [N][N];
  fp32_t src_b [N][N];
  fp32_t m_a   [N][N];
  fp32_t m_b   [N][N];
  bit    m_run = 1'b0;
  int    m_rel = 0;  // cycles since the edge that took the last beat
  int    m_nb  = 0;  // beats taken in the current load

  always @(posedge clk) begin
    if (!rst) begin
      m_run = 1'b0;
      m_rel = 0;
      m_nb  = 0;
    end else if (!m_run) begin
      if (in_valid) begin
        for (int j = 0; j < N; j++) begin
          m_a[m_nb][j] = lane(a_row, j);
          m_b[j][m_nb] = lane(b_col, j);
        end
        if (m_nb == N - 1) begin
          m_nb  = 0;
          m_run = 1'b1;
          m_rel = 1;
        end else begin
          m_nb++;
        end
      end
    end else begin
      m_rel++;
      if (m_rel > 2 * N + D + 1) begin
        m_run = 1'b0;
        m_rel = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    bit          feed_w;
    int          t;
    logic [31:0] ea, eb, es;
    feed_w = m_run && (m_rel >= 2) && (m_rel <= 2 * N);
    t      = m_rel - 2;
    if (!m_run)                es = 32'd0;
    else if (m_rel == 1)       es = 32'd1;
    else if (feed_w)           es = 32'd2;
    else if (m_rel <= 2*N + D) es = 32'd3;
    else                       es = 32'd4;
    check("in_ready", 32'(in_ready), 32'(!m_run));
    check("busy",     32'(busy),     32'(m_run));
    check("acc_clr",  32'(acc_clr),  32'(m_run && m_rel == 1));
    check("feeding",  32'(feeding),  32'(feed_w));
    check("done",     32'(done),     32'(m_run && m_rel == 2 * N + D + 1));
    check("state",    32'(dbg_state), es);
    check("k",        32'(dbg_k),    32'(m_nb));
    for (int i = 0; i < N; i++) begin
      ea = 32'h0;
      eb = 32'h0;
      if (feed_w && (t - i) >= 0 && (t - i) < N) begin
        ea = m_a[i][t-i];
        eb = m_b[t-i][i];
      end
      check($sformatf("sys_a[%0d]", i), lane(sys_a, i), ea);
      check($sformatf("sys_b[%0d]", i), lane(sys_b, i), eb);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pat[p] gives in_valid for step p; steps past plen are valid.
  task automatic drive_load(input logic [6:0] pat, input int plen);
    int k;
    int p;
    bit v;
    k = 0;
    p = 0;
    while (k < N) begin
      v = (p < plen) ? pat[p] : 1'b1;
      p++;
      if (v) begin
        in_valid = 1'b1;
        for (int j = 0; j < N; j++) begin
          a_row[j*DW +: DW] = src_a[k][j];
          b_col[j*DW +: DW] = src_b[j][k];
        end
        k++;
      end else begin
        in_valid = 1'b0;
        a_row    = {N{32'hBAD0BAD0}};
        b_col    = {N{32'hBAD1BAD1}};
      end
      tick();
    end
    in_valid = 1'b0;
    a_row    = '0;
    b_col    = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_run && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_tagged(input logic [31:0] abase, input logic [31:0] bbase);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        src_a[i][j] = abase + 32'(4 * i + j);
        src_b[i][j] = bbase + 32'(4 * i + j);
      end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    a_row    = '0;
    b_col    = '0;

    // Reset held for two edges.
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_sys_a",   sys_a[31:0] | sys_a[63:32] | sys_a[95:64] | sys_a[127:96], 32'h0);
    check("rst_sys_b",   sys_b[31:0] | sys_b[63:32] | sys_b[95:64] | sys_b[127:96], 32'h0);
    check("rst_ready",   32'(in_ready), 32'd1);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_acc_clr", 32'(acc_clr),  32'd0);
    check("rst_feeding", 32'(feeding),  32'd0);
    check("rst_done",    32'(done),     32'd0);
    tick();

    // Tagged load, back to back: A[k][j] = 4k+j+1, B[i][k] = 0x100+4i+k.
    set_tagged(32'h1, 32'h100);
    drive_load(7'h7F, 7);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      case (cyc)
        1: check("tag_acc_clr_c1", 32'(acc_clr), 32'd1);
        2: begin
          check("tag_acc_clr_c2", 32'(acc_clr), 32'd0);
          check("tag_feed_c2",    32'(feeding), 32'd1);
          check("tag_t0_a0", lane(sys_a, 0), 32'h1);
          check("tag_t0_a1", lane(sys_a, 1), 32'h0);
          check("tag_t0_a3", lane(sys_a, 3), 32'h0);
          check("tag_t0_b0", lane(sys_b, 0), 32'h100);
          check("tag_t0_b1", lane(sys_b, 1), 32'h0);
        end
        5: begin
          check("tag_t3_a0", lane(sys_a, 0), 32'h4);
          check("tag_t3_a1", lane(sys_a, 1), 32'h7);
          check("tag_t3_a2", lane(sys_a, 2), 32'hA);
          check("tag_t3_a3", lane(sys_a, 3), 32'hD);
        end
        8: begin
          check("tag_feed_c8", 32'(feeding), 32'd1);
          check("tag_t6_a0", lane(sys_a, 0), 32'h0);
          check("tag_t6_a2", lane(sys_a, 2), 32'h0);
          check("tag_t6_a3", lane(sys_a, 3), 32'h10);
          check("tag_t6_b3", lane(sys_b, 3), 32'h10F);
        end
        9:  check("tag_feed_c9",  32'(feeding), 32'd0);
        16: check("tag_done_c16", 32'(done), 32'd0);
        17: check("tag_done_c17", 32'(done), 32'd1);
        18: begin
          check("tag_done_c18",  32'(done),     32'd0);
          check("tag_ready_c18", 32'(in_ready), 32'd1);
        end
        default: ;
      endcase
    end
    tick();

    // Gapped load, then hold junk on the bus while the block is busy.
    set_tagged(32'h1000, 32'h2000);
    drive_load(7'b1011001, 7);
    in_valid = 1'b1;
    a_row    = {N{32'hDEADBEEF}};
    b_col    = {N{32'hDEADBEEF}};
    @(negedge clk);
    @(negedge clk);
    check("gap_t0_a0", lane(sys_a, 0), 32'h1000);
    check("gap_t0_b0", lane(sys_b, 0), 32'h2000);
    repeat (12) tick();
    in_valid = 1'b0;
    a_row    = '0;
    b_col    = '0;
    wait_idle();

    // fp32 operands, loaded in the first LOAD cycle after DONE.
    src_a[0] = '{32'h40800000, 32'h41000000, 32'h41400000, 32'h41800000};
    src_a[1] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    src_a[2] = '{32'hBF800000, 32'h3F000000, 32'hC0200000, 32'h3FC00000};
    src_a[3] = '{32'h7FC00001, 32'h80000000, 32'h00000001, 32'h7F800000};
    src_b[0] = '{32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    src_b[1] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    src_b[2] = '{32'hC0A00000, 32'h00000000, 32'h80000000, 32'h3E800000};
    src_b[3] = '{32'hFF800000, 32'h007FFFFF, 32'h42C80000, 32'hC2C80000};
    drive_load(7'h7F, 7);
    @(negedge clk);
    @(negedge clk);
    check("fp_t0_a0", lane(sys_a, 0), 32'h40800000);
    check("fp_t0_b0", lane(sys_b, 0), 32'h41500000);
    repeat (3) @(negedge clk);
    check("fp_t3_a0", lane(sys_a, 0), 32'h41800000);
    check("fp_t3_a3", lane(sys_a, 3), 32'h7FC00001);
    check("fp_t3_b0", lane(sys_b, 0), 32'hFF800000);
    check("fp_t3_b3", lane(sys_b, 3), 32'h41800000);
    tick();
    wait_idle();

    // Reset while FEED shows t=3; done must never follow.
    set_tagged(32'h5000, 32'h6000);
    drive_load(7'h7F, 7);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_a", sys_a[31:0] | sys_a[63:32] | sys_a[95:64] | sys_a[127:96], 32'h0);
    check("mid_rst_b", sys_b[31:0] | sys_b[63:32] | sys_b[95:64] | sys_b[127:96], 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_k",     32'(dbg_k),     32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    repeat (25) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Upstream feeder for systolic_array. Buffers one A matrix and one B matrix, each N x N IEEE-754 single precision, loaded through a valid/ready beat interface.
- Replays the matrices into the array's sys_a/sys_b edge ports with the diagonal skew an output-stationary array needs.
- After feeding, waits a fixed drain interval and pulses done so downstream logic can sample sys_r.

Parameters:
- N, 4, array dimension (rows = columns).
- DATA_W, 32, operand width in bits (fp32).
- DRAIN_CYCLES, 8, cycles after the last feed cycle until the results in sys_r are final.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  load beat valid.
- in_ready  out  1  load beat ready. High only in LOAD.
- a_row  in  N*DATA_W  row k of A. Slice j = A[k][j].
- b_col  in  N*DATA_W  column k of B. Slice i = B[i][k].
- sys_a  out  N x DATA_W  registered; drives systolic_array row inputs.
- sys_b  out  N x DATA_W  registered; drives systolic_array column inputs.
- acc_clr  out  1  one-cycle pulse that clears the array accumulators.
- feeding  out  1  high while skewed operands are being driven.
- busy  out  1  high in any state other than LOAD.
- done  out  1  one-cycle pulse when the results are final.

Behaviour:
- Reset is synchronous and active-low: every register updates only on the rising clk edge, and rst=0 at that edge resets the block.
- Reset values:
  - state = LOAD; beat counter k = 0; t = 0.
  - All sys_a and sys_b entries = 0.
  - acc_clr, feeding, busy, done = 0; in_ready = 1 in the first cycle after reset.
- Reset mid-operation aborts immediately with the same values. Buffer contents are don't-care after reset.
- FSM states: LOAD -> CLEAR -> FEED -> DRAIN -> DONE -> LOAD.
- LOAD:
  - A beat is accepted when in_valid and in_ready are both high. On acceptance, a_row is stored to Abuf[k], b_col to Bbuf[*][k], and k increments.
  - Gaps in in_valid are allowed.
  - On acceptance of beat k = N-1: k wraps to 0 and the next state is CLEAR.
- CLEAR:
  - Lasts 1 cycle: acc_clr = 1, sys_a and sys_b = 0, busy = 1.
- FEED:
  - Counter t runs 0..2N-2, one value per cycle. feeding = 1.
  - Outputs presented while the counter equals t:
    - sys_a[i] = Abuf[i][t-i] if 0 <= t-i < N, else 0.
    - sys_b[j] = Bbuf[t-j][j] if 0 <= t-j < N, else 0.
  - After t = 2N-2, the next state is DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles. sys_a and sys_b = 0, feeding = 0.
- DONE:
  - Lasts 1 cycle: done = 1, busy = 1, then LOAD.
- in_ready = 0 outside LOAD. in_valid outside LOAD is ignored and nothing is stored.
- Timing, with the last beat accepted at edge c:
  - acc_clr is high in cycle c+1.
  - FEED spans c+2 .. c+2N.
  - DRAIN spans c+2N+1 .. c+2N+DRAIN_CYCLES.
  - done is high in cycle c+2N+DRAIN_CYCLES+1.
  - in_ready returns high in the following cycle.
- The block does no arithmetic. Data passes bit-exact, with no fp normalisation. Zero padding is 32'h0 (+0.0).
- Back-to-back loads: a new load is accepted in the first LOAD cycle after DONE. There is no overlap of LOAD with FEED.

Decomposition:
- systolic_pkg holds:
  - the DATA_W and N localparam defaults;
  - typedef fp32_t = logic [31:0];
  - typedef enum skew_state_e {LOAD, CLEAR, FEED, DRAIN, DONE}.
- One sub-module is natural: skew_lane_mux. It is combinational. Given lane index, t and a buffered N-vector, it returns the element at t-lane or 0. It is instantiated 2N times, once per A lane and once per B lane.

Test Plan:
- Reset: hold rst=0 for 2 edges, then release. Required: sys_a and sys_b all 0; in_ready=1; busy, acc_clr, feeding and done all 0.
- Tagged load: A[k][j] = 32'h(4k+j+1); B[i][k] = 32'h100+4i+k; 4 back-to-back beats. Required:
  - t=0: sys_a = {1,0,0,0}, sys_b[0] = 32'h100.
  - t=3: sys_a = {4,7,0xA,0xD}.
  - t=6: sys_a = {0,0,0,0x10}, sys_b[3] = 32'h10F.
- Timing: N=4, DRAIN=8, last beat at edge c. Required:
  - acc_clr high at c+1 only.
  - feeding high c+2..c+8.
  - done high at c+17 only.
  - in_ready high again at c+18.
- Backpressure and gaps: in_valid toggles 1,0,0,1,1,0,1. Required: exactly 4 beats captured, in order; the CLEAR state follows the 4th accepted beat.
- Ignore while busy: hold in_valid=1 with a_row=32'hDEADBEEF throughout FEED. Required: no buffer change; the next run's outputs match that run's loaded data.
- Reset mid-FEED (t=3): rst=0 for 1 edge. Required: the next cycle shows sys_a and sys_b all 0, state LOAD, k=0, and done never pulses.
- fp32 data from the systolic_array bench: A rows {4,8,12,16}..., B {13,14,15,16}... (e.g. 32'h40800000, 32'h41500000). Required: the values appear unaltered on the skewed lanes at the t given by the FEED formula.
